// File: rtl/mult_div_pkg.sv
// Shared widths, state encoding and counter sizing for the product divider.
package mult_div_pkg;

  localparam int DIVIDEND_W = 6;
  localparam int DIVISOR_W  = 3;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_product_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
  import mult_div_pkg::*;
#(
  parameter int DIVISOR_W = mult_div_pkg::DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   p,
  input  logic                 dbit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   p_next,
  output logic                 qbit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  // p < divisor on entry, so a successful subtraction always fits in DIVISOR_W+1 bits
  always_comb begin
    shifted = {p, dbit};
    diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
    qbit    = (shifted >= {2'b00, divisor});
    p_next  = qbit ? diff : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/restoring_product_divider.sv
// Sequential restoring divider recovering an operand from a multiplier product.
// Optional reconstruction check enabled by defining DIV_SELFCHECK_EN.
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | one restoring step per clock, dividend MSB first
// DONE  | result presented until out_ready
module restoring_product_divider
  import mult_div_pkg::*;
#(
  parameter int DIVIDEND_W = mult_div_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = mult_div_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  chk_err
);

  localparam int CNT_BITS = $clog2(DIVIDEND_W);

  state_t                state, state_nxt;
  logic [CNT_BITS-1:0]   cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    p, p_next;
  logic [DIVIDEND_W-2:0] q;
  logic [DIVIDEND_W-1:0] q_full;
  logic                  qbit;
  logic                  dbz_wait;
  logic                  chk_nxt;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .p       (p),
    .dbit    (dvd[cnt]),
    .divisor (dvs),
    .p_next  (p_next),
    .qbit    (qbit)
  );

  assign q_full = {q, qbit};

`ifdef DIV_SELFCHECK_EN
  localparam int PW = DIVIDEND_W + DIVISOR_W;
  logic [PW-1:0] recon;
  logic          chk_r;

  always_comb begin
    recon   = PW'(q_full) * PW'(dvs) + PW'(p_next[DIVISOR_W-1:0]);
    chk_nxt = (recon != PW'(dvd));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      chk_r <= 1'b0;
    end else if (state == RUN && cnt == '0) begin
      chk_r <= chk_nxt;
    end
  end

  assign chk_err = chk_r;
`else
  assign chk_nxt = 1'b0;
  assign chk_err = chk_nxt;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready && !dbz_wait) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // a zero divisor skips RUN but still waits one clock so its result lands at T+1
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE) && !dbz_wait;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      p           <= '0;
      q           <= '0;
      dbz_wait    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= dividend;
            dvs <= divisor;
            p   <= '0;
            q   <= '0;
            cnt <= CNT_BITS'(DIVIDEND_W - 1);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              dbz_wait    <= 1'b1;
            end
          end
        end
        RUN: begin
          p   <= p_next;
          q   <= q_full[DIVIDEND_W-2:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient    <= q_full;
            remainder   <= p_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: dbz_wait <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_product_divider.sv
// Self-checking bench: directed cases, backpressure, mid-run reset, full sweep and random ops.
module tb_restoring_product_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;
  logic       chk_err;

  int checks = 0;
  int errors = 0;

  restoring_product_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .chk_err     (chk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference: plain integer division, all-ones quotient on a zero divisor
  task automatic model(input int a, input int b, output int eq, output int er, output int ez,
                       output int elat);
    if (b == 0) begin
      eq = 63; er = 0; ez = 1; elat = 1;
    end else begin
      eq = a / b; er = a % b; ez = 0; elat = 6;
    end
  endtask

  task automatic wait_valid(input string tag, input int elat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int eq, er, ez, elat;
    model(a, b, eq, er, ez, elat);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, ez);
    chk({tag, " chk_err"}, chk_err, 0);
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int eq, er, ez, elat;
    model(a, b, eq, er, ez, elat);
    dividend = 6'(a);
    divisor  = 3'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    chk({tag, " in_ready busy"}, in_ready, 0);
    wait_valid(tag, elat);
    check_result(tag, a, b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " in_ready after"}, in_ready, 1);
    chk({tag, " out_valid after"}, out_valid, 0);
  endtask

  initial begin
    int eq, er, ez, elat, stale;
    logic [5:0] hq;
    logic [2:0] hr;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    chk("reset chk_err", chk_err, 0);

    run_op("30/5", 30, 5);
    run_op("47/3", 47, 3);
    run_op("5/7", 5, 7);
    run_op("63/1", 63, 1);
    run_op("18/0", 18, 0);

    // backpressure, with a second request held from the start of the first
    dividend = 6'd47; divisor = 3'd3; in_valid = 1'b1;
    tick();
    dividend = 6'd63; divisor = 3'd1;
    wait_valid("bp first", 6);
    hq = quotient;
    hr = remainder;
    for (int i = 0; i < 5; i++) begin
      chk("bp quotient stable", quotient, 15);
      chk("bp remainder stable", remainder, 2);
      chk("bp out_valid held", out_valid, 1);
      chk("bp in_ready low", in_ready, 0);
      tick();
    end
    chk("bp quotient unchanged", quotient, hq);
    chk("bp remainder unchanged", remainder, hr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp in_ready after handshake", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp second accepted", in_ready, 0);
    wait_valid("bp second", 6);
    check_result("bp second", 63, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset during RUN discards the operation
    dividend = 6'd30; divisor = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst quotient", quotient, 0);
    chk("midrst remainder", remainder, 0);
    chk("midrst div_by_zero", div_by_zero, 0);
    chk("midrst chk_err", chk_err, 0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("midrst no stale result", stale, 0);
    run_op("post reset 47/3", 47, 3);

    // reset while holding a result in DONE
    dividend = 6'd20; divisor = 3'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("done rst", 6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("done rst out_valid", out_valid, 0);
    chk("done rst quotient", quotient, 0);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_op($sformatf("sweep %0d/%0d", a, b), a, b);
      end
    end

    for (int i = 0; i < 40; i++) begin
      int ra, rb;
      ra = int'($urandom_range(63));
      rb = int'($urandom_range(7));
      run_op($sformatf("rand %0d/%0d", ra, rb), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
